// File: rtl/free_list_pkg.sv
// Shared sizes and types for the rename free list.
// Optional same-cycle release forwarding: FREE_LIST_BYPASS_EN.
package free_list_pkg;

   localparam int FL_PRF_SIZE    = 64;
   localparam int FL_ARF_SIZE    = 32;
   localparam int FL_RENAME_W    = 4;
   localparam int FL_COMMIT_W    = 4;
   localparam int PRF_INDEX_SIZE = $clog2(FL_PRF_SIZE);
   localparam int FL_PTR_W       = PRF_INDEX_SIZE + 1;

   typedef logic [PRF_INDEX_SIZE-1:0] prf_index_t;
   typedef logic [FL_PTR_W-1:0]       fl_ptr_t;

endpackage

// File: rtl/free_list_if.sv
// Rename/commit/recovery bundle between the free list and its users.
// The wrap bit sits on top of every pointer-sized field.
interface free_list_if
   import free_list_pkg::*;
#(
   parameter int PRF_SIZE     = FL_PRF_SIZE,
   parameter int RENAME_WIDTH = FL_RENAME_W,
   parameter int COMMIT_WIDTH = FL_COMMIT_W
);

   localparam int IW = $clog2(PRF_SIZE);
   localparam int PW = IW + 1;

   logic                             pause;
   logic                             recover;
   logic [PW-1:0]                    recover_head;
   logic [RENAME_WIDTH-1:0]          alloc_req;
   logic [RENAME_WIDTH-1:0][IW-1:0]  alloc_prf;
   logic                             allocatable;
   logic [COMMIT_WIDTH-1:0]          free_valid;
   logic [COMMIT_WIDTH-1:0][IW-1:0]  free_prf;
   logic [PW-1:0]                    head_ptr;
   logic [PW-1:0]                    free_count;

   modport master (
      output pause, recover, recover_head,
      output alloc_req, free_valid, free_prf,
      input  alloc_prf, allocatable,
      input  head_ptr, free_count
   );

   modport slave (
      input  pause, recover, recover_head,
      input  alloc_req, free_valid, free_prf,
      output alloc_prf, allocatable,
      output head_ptr, free_count
   );

endinterface

// File: rtl/free_list_prefix.sv
// Exclusive prefix popcount of an N-bit mask plus its total.
// Gives each set bit its rank among the set bits below it.
module free_list_prefix #(
   parameter int N  = 4,
   parameter int CW = $clog2(N + 1)
) (
   input  logic [N-1:0]         mask_i,
   output logic [N-1:0][CW-1:0] off_o,
   output logic [CW-1:0]        total_o
);

   logic [CW-1:0] acc;

   always_comb begin
      acc = '0;
      for (int i = 0; i < N; i++) begin
         off_o[i] = acc;
         acc      = acc + CW'(mask_i[i]);
      end
      total_o = acc;
   end

endmodule

// File: rtl/free_list.sv
// Circular free list of PRF tags for rename; head is checkpointable.
// Define FREE_LIST_BYPASS_EN to forward same-cycle releases to grants.
module free_list
   import free_list_pkg::*;
#(
   parameter int PRF_SIZE     = FL_PRF_SIZE,
   parameter int ARF_SIZE     = FL_ARF_SIZE,
   parameter int RENAME_WIDTH = FL_RENAME_W,
   parameter int COMMIT_WIDTH = FL_COMMIT_W,
   parameter int PTR_W        = $clog2(PRF_SIZE) + 1
) (
   input logic        clock,
   input logic        reset,
   free_list_if.slave bus
);

   localparam int IW = PTR_W - 1;
   localparam int AW = $clog2(RENAME_WIDTH + 1);
   localparam int RW = $clog2(COMMIT_WIDTH + 1);

   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [IW-1:0]    ent_q [PRF_SIZE];
   logic [IW-1:0]    ent_d [PRF_SIZE];

   logic [RENAME_WIDTH-1:0][AW-1:0]    a_off;
   logic [AW-1:0]                      a_tot;
   logic [COMMIT_WIDTH-1:0][RW-1:0]    r_off;
   logic [RW-1:0]                      r_tot;
   logic [RENAME_WIDTH-1:0][PTR_W-1:0] gidx;
   logic [COMMIT_WIDTH-1:0][PTR_W-1:0] widx;
   logic [PTR_W-1:0]                   cnt;
   logic                               alloc_ok;
   logic                               fire;

   free_list_prefix #(.N(RENAME_WIDTH)) u_alloc (
      .mask_i  (bus.alloc_req),
      .off_o   (a_off),
      .total_o (a_tot)
   );

   free_list_prefix #(.N(COMMIT_WIDTH)) u_rel (
      .mask_i  (bus.free_valid),
      .off_o   (r_off),
      .total_o (r_tot)
   );

   assign cnt = tail_q - head_q;

`ifdef FREE_LIST_BYPASS_EN
   assign alloc_ok = ({1'b0, cnt} + (PTR_W+1)'(r_tot))
                     >= (PTR_W+1)'(RENAME_WIDTH);
`else
   assign alloc_ok = cnt >= PTR_W'(RENAME_WIDTH);
`endif

   assign fire = |bus.alloc_req & alloc_ok
                 & ~bus.pause & ~bus.recover;

   // Requesting slots take consecutive tags in slot order
   always_comb begin
      for (int i = 0; i < RENAME_WIDTH; i++) begin
         gidx[i]          = head_q + PTR_W'(a_off[i]);
         bus.alloc_prf[i] = ent_q[gidx[i][IW-1:0]];
`ifdef FREE_LIST_BYPASS_EN
         for (int j = 0; j < COMMIT_WIDTH; j++) begin
            if (bus.free_valid[j] &&
                PTR_W'(r_off[j]) == gidx[i] - tail_q) begin
               bus.alloc_prf[i] = bus.free_prf[j];
            end
         end
`endif
      end
   end

   always_comb begin
      head_d = head_q;
      if (bus.recover) begin
         head_d = bus.recover_head;
      end else if (fire) begin
         head_d = head_q + PTR_W'(a_tot);
      end
   end

   always_comb begin
      tail_d = tail_q + PTR_W'(r_tot);
      ent_d  = ent_q;
      for (int j = 0; j < COMMIT_WIDTH; j++) begin
         widx[j] = tail_q + PTR_W'(r_off[j]);
         if (bus.free_valid[j]) begin
            ent_d[widx[j][IW-1:0]] = bus.free_prf[j];
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         head_q <= '0;
         tail_q <= PTR_W'(PRF_SIZE - ARF_SIZE);
         for (int i = 0; i < PRF_SIZE; i++) begin
            ent_q[i] <= (i < PRF_SIZE - ARF_SIZE)
                        ? IW'(ARF_SIZE + i) : '0;
         end
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         ent_q  <= ent_d;
      end
   end

   assign bus.allocatable = alloc_ok;
   assign bus.head_ptr    = head_q;
   assign bus.free_count  = cnt;

endmodule

// File: tb/tb_free_list.sv
// Randomized scoreboard bench for free_list against a queue-level model.
// Model positions are unbounded integers; pointers are taken mod 128.
module tb_free_list;
   import free_list_pkg::*;

   typedef struct {
      logic            alc;
      logic [6:0]      hp;
      logic [6:0]      fc;
      logic [3:0]      chk;
      logic [3:0][5:0] tags;
   } exp_t;

   typedef struct {
      int     tag;
      longint pos;
   } live_t;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   free_list_if bus ();

   free_list dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   exp_t   sb [$];
   live_t  live [$];
   int     mem [longint];
   longint head_a, tail_a;
   bit     ck_v;
   longint ck_a;
   int     n_cmp = 0;
   int     n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d required %0d", nm, act, exp);
      end
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("allocatable", 32'(bus.allocatable), 32'(e.alc));
            chk("head_ptr", 32'(bus.head_ptr), 32'(e.hp));
            chk("free_count", 32'(bus.free_count), 32'(e.fc));
            for (int i = 0; i < 4; i++) begin
               if (e.chk[i]) begin
                  chk($sformatf("alloc_prf[%0d]", i),
                      32'(bus.alloc_prf[i]), 32'(e.tags[i]));
               end
            end
         end
      end
   end

   task automatic model_reset();
      head_a = 0;
      tail_a = 32;
      mem.delete();
      for (int i = 0; i < 32; i++) mem[longint'(i)] = 32 + i;
      live.delete();
      ck_v = 1'b0;
   endtask

   task automatic drive_idle();
      bus.alloc_req    = '0;
      bus.pause        = 1'b0;
      bus.recover      = 1'b0;
      bus.recover_head = '0;
      bus.free_valid   = '0;
      bus.free_prf     = '0;
   endtask

   task automatic do_reset(input bit busy);
      reset = 1'b1;
      drive_idle();
      if (busy) begin
         bus.alloc_req  = 4'($urandom);
         bus.free_valid = 4'($urandom);
         bus.free_prf   = 24'($urandom);
      end
      @(posedge clock);
      #1;
      reset = 1'b0;
      drive_idle();
      model_reset();
   endtask

   task automatic cycle(input logic [3:0] req, input bit ps, input bit rc,
                        input logic [6:0] rh, input logic [3:0] fv,
                        input logic [3:0][5:0] fp, output bit fired,
                        output logic [3:0][5:0] g);
      exp_t   e;
      longint cnt, pos;
      int     rt, k, n;
      bus.alloc_req    = req;
      bus.pause        = ps;
      bus.recover      = rc;
      bus.recover_head = rh;
      bus.free_valid   = fv;
      bus.free_prf     = fp;
      cnt = tail_a - head_a;
      rt  = $countones(fv);
`ifdef FREE_LIST_BYPASS_EN
      e.alc = (cnt + rt) >= 4;
`else
      e.alc = cnt >= 4;
`endif
      e.hp   = 7'(head_a % 128);
      e.fc   = 7'(cnt);
      e.chk  = '0;
      e.tags = '0;
      k = 0;
      for (int i = 0; i < 4; i++) begin
         if (req[i]) begin
            pos = head_a + k;
            k++;
            if (pos < tail_a) begin
               e.tags[i] = 6'(mem[pos]);
               e.chk[i]  = 1'b1;
            end
`ifdef FREE_LIST_BYPASS_EN
            else if (pos - tail_a < rt) begin
               n = 0;
               for (int j = 0; j < 4; j++) begin
                  if (fv[j]) begin
                     if (n == pos - tail_a) e.tags[i] = fp[j];
                     n++;
                  end
               end
               e.chk[i] = 1'b1;
            end
`endif
         end
      end
      g = e.tags;
      sb.push_back(e);
      fired = (req != 0) && e.alc && !ps && !rc;
      @(posedge clock);
      n = 0;
      for (int j = 0; j < 4; j++) begin
         if (fv[j]) begin
            mem[tail_a + n] = int'(fp[j]);
            n++;
         end
      end
      tail_a += rt;
      if (rc) head_a -= (head_a - longint'(rh)) & 127;
      else if (fired) head_a += $countones(req);
      #1;
   endtask

   task automatic idle(output bit f, output logic [3:0][5:0] g);
      cycle(4'b0000, 0, 0, '0, 4'b0000, '0, f, g);
   endtask

   task automatic rand_cycle();
      logic [3:0]      req, fv;
      logic [3:0][5:0] fp, g;
      logic [6:0]      rh;
      bit              ps, rc, fired;
      longint          base;
      int              idx, k;
      req = 4'($urandom);
      ps  = ($urandom % 8) == 0;
      rc  = 1'b0;
      rh  = '0;
      if (!ck_v && ($urandom % 6) == 0) begin
         ck_v = 1'b1;
         ck_a = head_a;
      end else if (ck_v && ($urandom % 10) == 0) begin
         rc = 1'b1;
         rh = 7'(ck_a % 128);
      end
      fv = '0;
      fp = '0;
      for (int j = 0; j < 4; j++) begin
         if ($urandom % 2 == 1 && live.size() != 0) begin
            idx = int'($urandom % live.size());
            if (!ck_v || live[idx].pos < ck_a) begin
               fv[j] = 1'b1;
               fp[j] = 6'(live[idx].tag);
               live.delete(idx);
            end
         end
      end
      base = head_a;
      cycle(req, ps, rc, rh, fv, fp, fired, g);
      if (fired) begin
         k = 0;
         for (int i = 0; i < 4; i++) begin
            if (req[i]) begin
               live.push_back('{int'(g[i]), base + k});
               k++;
            end
         end
      end
      if (rc) begin
         for (int i = live.size() - 1; i >= 0; i--) begin
            if (live[i].pos >= ck_a) live.delete(i);
         end
         ck_v = 1'b0;
      end
   endtask

   initial begin
      bit              f;
      logic [3:0][5:0] g;
      drive_idle();
      do_reset(1'b0);
      idle(f, g);
      cycle(4'b1111, 0, 0, '0, 4'b0000, '0, f, g);
      idle(f, g);

      do_reset(1'b1);
      cycle(4'b1010, 0, 0, '0, 4'b0000, '0, f, g);
      repeat (6) cycle(4'b1111, 0, 0, '0, 4'b0000, '0, f, g);
      cycle(4'b0111, 0, 0, '0, 4'b0000, '0, f, g);
      repeat (2) cycle(4'b1111, 0, 0, '0, 4'b0000, '0, f, g);
      cycle(4'b0000, 0, 0, '0, 4'b0011, {6'd0, 6'd0, 6'd7, 6'd5}, f, g);
      idle(f, g);

      do_reset(1'b0);
      repeat (2) cycle(4'b1111, 0, 0, '0, 4'b0000, '0, f, g);
      repeat (3) cycle(4'b1111, 0, 0, '0, 4'b0000, '0, f, g);
      cycle(4'b1111, 0, 1, 7'd8, 4'b0000, '0, f, g);
      cycle(4'b1111, 0, 0, '0, 4'b0000, '0, f, g);
      idle(f, g);

      do_reset(1'b0);
      repeat (8) cycle(4'b1111, 0, 0, '0, 4'b0000, '0, f, g);
      cycle(4'b1111, 0, 0, '0, 4'b1111,
            {6'd12, 6'd11, 6'd10, 6'd9}, f, g);
      idle(f, g);

      do_reset(1'b0);
      repeat (3000) rand_cycle();
      do_reset(1'b1);
      idle(f, g);
      cycle(4'b1111, 0, 0, '0, 4'b0000, '0, f, g);

      drive_idle();
      repeat (2) @(posedge clock);
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
